// File: rtl/seg7_scan_decoder.sv
// Recovers the value shown on a multiplexed, active-low 4-digit 7-segment display
// by watching its segment, anode and decimal-point lines.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [15:0] word_out,
  output logic [3:0]  dp_out,
  output logic        word_valid,
  output logic        digit_err,
  output logic        frame_stale
);

  // state    | meaning
  // SETTLING | sample changed recently; waiting for it to hold steady
  // HELD     | current stable sample already accepted once
  typedef enum logic {
    SETTLING = 1'b0,
    HELD     = 1'b1
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT_CYCLES - 1);

  state_t         state;
  logic [11:0]    samp_q;
  logic [11:0]    prev_q;
  logic [SW-1:0]  settle_q;
  logic [SW-1:0]  settle_nxt;
  logic [IW-1:0]  idle_q;
  logic [15:0]    shadow_q;
  logic [3:0]     sdp_q;
  logic [3:0]     mask_q;

  logic [3:0]     s_an;
  logic [6:0]     s_seg;
  logic           s_dp;
  logic           same;
  logic           one_hot;
  logic [1:0]     slot;
  logic [6:0]     glyph;
  logic           glyph_ok;
  logic [3:0]     glyph_nib;
  logic           accept;
  logic [15:0]    shadow_nxt;
  logic [3:0]     sdp_nxt;
  logic [3:0]     mask_set;

  assign s_an  = samp_q[11:8];
  assign s_seg = samp_q[7:1];
  assign s_dp  = samp_q[0];
  assign same  = (samp_q == prev_q);
  assign glyph = ~s_seg;

  always_comb begin
    settle_nxt = '0;
    if (same) begin
      if (settle_q == SETTLE_LAST) settle_nxt = settle_q;
      else                         settle_nxt = settle_q + 1'b1;
    end
  end

  // Exactly one anode driven low selects a digit; anything else is blanking or ghosting.
  always_comb begin
    one_hot = 1'b1;
    slot    = 2'd0;
    case (s_an)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_nib = 4'h0;
    case (glyph)
      7'h3F: glyph_nib = 4'h0;
      7'h06: glyph_nib = 4'h1;
      7'h5B: glyph_nib = 4'h2;
      7'h4F: glyph_nib = 4'h3;
      7'h66: glyph_nib = 4'h4;
      7'h6D: glyph_nib = 4'h5;
      7'h7D: glyph_nib = 4'h6;
      7'h07: glyph_nib = 4'h7;
      7'h7F: glyph_nib = 4'h8;
      7'h6F: glyph_nib = 4'h9;
      7'h77: glyph_nib = 4'hA;
      7'h7C: glyph_nib = 4'hB;
      7'h39: glyph_nib = 4'hC;
      7'h5E: glyph_nib = 4'hD;
      7'h79: glyph_nib = 4'hE;
      7'h71: glyph_nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // Accept on the edge where the settle count first reaches its terminal value.
  assign accept = (state == SETTLING) && one_hot && (settle_nxt == SETTLE_LAST);

  always_comb begin
    shadow_nxt = shadow_q;
    shadow_nxt[{slot, 2'b00} +: 4] = glyph_nib;
    sdp_nxt = sdp_q;
    sdp_nxt[slot] = ~s_dp;
    mask_set = mask_q | (4'b0001 << slot);
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      samp_q   <= '1;
      prev_q   <= '1;
      settle_q <= '0;
      state    <= SETTLING;
    end else begin
      samp_q   <= {an, seg, dp};
      prev_q   <= samp_q;
      settle_q <= settle_nxt;
      case (state)
        SETTLING: if (accept) state <= HELD;
        HELD:     if (!same)  state <= SETTLING;
        default:  state <= SETTLING;
      endcase
    end
  end

  // Frame assembly, idle timeout and the registered outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      idle_q      <= '0;
      shadow_q    <= '0;
      sdp_q       <= '0;
      mask_q      <= '0;
      word_out    <= '0;
      dp_out      <= '0;
      word_valid  <= 1'b0;
      digit_err   <= 1'b0;
      frame_stale <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      digit_err  <= 1'b0;
      if (accept) begin
        idle_q <= '0;
        if (!glyph_ok) begin
          digit_err <= 1'b1;
        end else begin
          shadow_q <= shadow_nxt;
          sdp_q    <= sdp_nxt;
          if (mask_set == 4'hF) begin
            word_out    <= shadow_nxt;
            dp_out      <= sdp_nxt;
            word_valid  <= 1'b1;
            frame_stale <= 1'b0;
            mask_q      <= '0;
          end else begin
            mask_q <= mask_set;
          end
        end
      end else if (idle_q == IDLE_LAST) begin
        idle_q      <= '0;
        mask_q      <= '0;
        frame_stale <= 1'b1;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

endmodule
